dice_roll_controller: RTL and testbench
=======================================

# dice_roll_controller

Sequencer for the five-dice datapath. It owns the dice values driven to the seven-segment display controller. It runs a rolling animation on request, respects per-die hold flags, and enforces the per-turn roll limit. It sits between the debounced button/switch front end and the display controller plus the game FSM, which starts turns and consumes `roll_done`.

## Interface
- `MAX_ROLLS`, 3: rolls allowed per turn (1..3).
- `ANIM_TICKS`, 2_500_000: clock cycles from roll acceptance to final dice.
- `FRAME_DIV`, 250_000: cycles between animated dice updates; must be less than or equal to `ANIM_TICKS`.
- `clk` in 1: system clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `turn_start` in 1: single-cycle pulse that starts a new turn.
- `roll_req` in 1: single-cycle debounced roll pulse.
- `hold_toggle` in 5: per-die single-cycle toggle pulses; bit i maps to die i+1.
- `d1`..`d5` out 3 each: die values, 0 = no value yet, else 1..6.
- `hold` out 5: current hold flags.
- `rolls_left` out 2: remaining rolls this turn.
- `busy` out 1: high while animating.
- `roll_done` out 1: one-cycle pulse when final dice are valid.
- `dice_valid` out 1: high once the first roll of the turn has completed.

## Operation
- States: IDLE (no turn), READY (awaiting roll/hold), ROLL (animating), LOCKED (no rolls left).
- Reset: state IDLE; `d1`..`d5`=0, `hold`=0, `rolls_left`=0, `busy`=0, `roll_done`=0, `dice_valid`=0; LFSR=16'hACE1.
- `turn_start`, any state, highest priority:
  - Go to READY.
  - `rolls_left`=`MAX_ROLLS`, `hold`=0, all dice=0, `dice_valid`=0.
  - Any animation in progress is aborted and `roll_done` is not pulsed.
- READY + `roll_req`:
  - If all five held: ignored, no decrement.
  - Otherwise: go to ROLL, decrement `rolls_left`, clear counters.
- READY + `hold_toggle`: XOR into `hold`, only when `dice_valid`=1; ignored otherwise.
- Simultaneous `roll_req` and `hold_toggle` in READY: toggles are applied first. The roll uses the updated holds, including the all-held check.
- ROLL behaviour:
  - Every `FRAME_DIV` cycles, non-held dice load new values.
  - On the cycle the tick counter reaches `ANIM_TICKS`-1, non-held dice load their final values, `roll_done`=1, and `dice_valid`=1.
  - Next state is READY if `rolls_left`>0, else LOCKED.
  - Held dice never change.
- In ROLL, `roll_req` and `hold_toggle` are ignored.
- In IDLE and LOCKED, `roll_req` and `hold_toggle` are ignored.
- Random source:
  - 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, stepping every clock in all states.
  - Die i value = (lfsr[3i+2:3i] mod 6)+1, giving 1..6; slices 6 and 7 map to 1 and 2.
- `busy` = (state==ROLL).

## Timing
- `roll_req` sampled high in READY at edge t:
  - Edge t: `busy`=1 and `rolls_left` decremented.
  - Edge t+`ANIM_TICKS`: final dice registered and `roll_done`=1.
  - Edge t+`ANIM_TICKS`+1: `roll_done`=0, `busy`=0, READY/LOCKED.
- Animated updates occur at edges t+k·`FRAME_DIV` for k≥1, while before t+`ANIM_TICKS`.
- All outputs are registered; no combinational input-to-output paths.
- `turn_start` takes effect at the next edge. It overrides a coincident final animation edge: no `roll_done` pulse, dice=0.
- Reset asserted mid-ROLL: asynchronous return to reset values; no `roll_done` pulse.
- Counters are sized by $clog2 of their parameters. The tick counter saturates internally; there is no wrap dependence.

## Structure
- Shared package `yacht_pkg`:
  - State encoding enum.
  - `MAX_ROLLS` default.
  - LFSR seed 16'hACE1 and tap mask 16'hB400.
  - Die-mapping function (3-bit slice to 1..6).
- Sub-module `dice_lfsr`: free-running 16-bit Galois LFSR with asynchronous active-low reset to the seed; output is the 16-bit state.
- Top level holds the FSM, tick/frame counters, hold register and dice registers.

## Test plan
All scenarios use `ANIM_TICKS`=8, `FRAME_DIV`=2.
- Reset then idle 20 cycles: all outputs 0; `roll_req` pulses ignored; state stays IDLE.
- `turn_start`, then `roll_req` at edge t:
  - `busy`=1 at t; `rolls_left` 3→2 at t.
  - `roll_done` is a single pulse at t+8.
  - All dice in 1..6 and equal to the LFSR-mapped reference model; `dice_valid`=1.
- After the first roll, toggle holds for dice 1 and 3 (`hold`=5'b00101), then roll: d1 and d3 are unchanged throughout the animation; others match the model.
- Three completed rolls: `rolls_left`=0; state LOCKED; a fourth `roll_req` produces no `busy` and no dice change.
- `turn_start` at t+4 of an animation:
  - Next edge: `busy`=0, dice=0, `hold`=0, `rolls_left`=3.
  - No `roll_done` pulse at t+8.
- All five held plus `roll_req`: ignored, `rolls_left` unchanged. Separately, `hold_toggle`=5'b11111 coincident with `roll_req` while none are held: the roll is ignored.

Source files
------------

// File: rtl/yacht_pkg.sv
// ============================================================================
// Module   : yacht_pkg
// Purpose  : Shared types, LFSR constants and die mapping for the dice datapath
// Revision : 1.0
// ============================================================================
`default_nettype none

package yacht_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READY  = 2'd1,
    ST_ROLL   = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  localparam int          DEFAULT_MAX_ROLLS = 3;
  localparam logic [15:0] LFSR_SEED         = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;

  // Slice mod 6 plus one; slices 6 and 7 fold onto 1 and 2.
  function automatic logic [2:0] die_map(input logic [2:0] slice);
    return (slice >= 3'd6) ? (slice - 3'd5) : (slice + 3'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dice_lfsr.sv
// ============================================================================
// Module   : dice_lfsr
// Purpose  : Free-running 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1
// Revision : 1.0
// ============================================================================
`default_nettype none

module dice_lfsr
  import yacht_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] lfsr
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ LFSR_TAPS;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr = lfsr_q;

endmodule

`default_nettype wire

// File: rtl/dice_roll_controller.sv
// ============================================================================
// Module   : dice_roll_controller
// Purpose  : Turn sequencer for five dice: roll animation, holds, roll limit
// Revision : 1.0
// ============================================================================
`default_nettype none

module dice_roll_controller
  import yacht_pkg::*;
#(
  parameter int MAX_ROLLS  = DEFAULT_MAX_ROLLS,
  parameter int ANIM_TICKS = 2_500_000,
  parameter int FRAME_DIV  = 250_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       turn_start,
  input  logic       roll_req,
  input  logic [4:0] hold_toggle,
  output logic [2:0] d1,
  output logic [2:0] d2,
  output logic [2:0] d3,
  output logic [2:0] d4,
  output logic [2:0] d5,
  output logic [4:0] hold,
  output logic [1:0] rolls_left,
  output logic       busy,
  output logic       roll_done,
  output logic       dice_valid
);

  localparam int TW = (ANIM_TICKS > 1) ? $clog2(ANIM_TICKS) : 1;
  localparam int FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(ANIM_TICKS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_DIV - 1);
  localparam logic [1:0]    ROLLS_INIT = 2'(MAX_ROLLS);

  logic [15:0] lfsr;

  state_t          state_q, state_d;
  logic [4:0]      hold_q, hold_d;
  logic [1:0]      rolls_q, rolls_d;
  logic [4:0][2:0] dice_q, dice_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            valid_q, valid_d;
  logic [4:0][2:0] dice_new;

  dice_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (reset_n),
    .lfsr  (lfsr)
  );

  always_comb begin
    dice_new = dice_q;
    for (int i = 0; i < 5; i++) begin
      if (!hold_q[i]) begin
        dice_new[i] = die_map(lfsr[3*i +: 3]);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    rolls_d = rolls_q;
    dice_d  = dice_q;
    tick_d  = tick_q;
    frame_d = frame_q;
    done_d  = 1'b0;
    valid_d = valid_q;

    if (turn_start) begin
      state_d = ST_READY;
      rolls_d = ROLLS_INIT;
      hold_d  = '0;
      dice_d  = '0;
      valid_d = 1'b0;
      tick_d  = '0;
      frame_d = '0;
    end else begin
      case (state_q)
        ST_READY: begin
          // Toggles land first so the all-held check sees the new holds.
          if (valid_q) begin
            hold_d = hold_q ^ hold_toggle;
          end
          if (roll_req && (hold_d != 5'h1F)) begin
            state_d = ST_ROLL;
            rolls_d = rolls_q - 2'd1;
            tick_d  = '0;
            frame_d = '0;
          end
        end
        ST_ROLL: begin
          if (tick_q == TICK_LAST) begin
            dice_d  = dice_new;
            done_d  = 1'b1;
            valid_d = 1'b1;
            state_d = (rolls_q != 2'd0) ? ST_READY : ST_LOCKED;
          end else begin
            tick_d = tick_q + 1'b1;
            if (frame_q == FRAME_LAST) begin
              frame_d = '0;
              dice_d  = dice_new;
            end else begin
              frame_d = frame_q + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end

    // Busy stays up through the roll_done cycle and drops on the next edge.
    busy_d = (state_d == ST_ROLL) || done_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      rolls_q <= '0;
      dice_q  <= '0;
      tick_q  <= '0;
      frame_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      rolls_q <= rolls_d;
      dice_q  <= dice_d;
      tick_q  <= tick_d;
      frame_q <= frame_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  assign d1         = dice_q[0];
  assign d2         = dice_q[1];
  assign d3         = dice_q[2];
  assign d4         = dice_q[3];
  assign d5         = dice_q[4];
  assign hold       = hold_q;
  assign rolls_left = rolls_q;
  assign busy       = busy_q;
  assign roll_done  = done_q;
  assign dice_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_dice_roll_controller.sv
// ============================================================================
// Module   : tb_dice_roll_controller
// Purpose  : Directed self-checking bench for dice_roll_controller
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dice_roll_controller;

  localparam int ANIM = 8;
  localparam int FDIV = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       turn_start = 1'b0;
  logic       roll_req = 1'b0;
  logic [4:0] hold_toggle = 5'd0;
  logic [2:0] d1, d2, d3, d4, d5;
  logic [4:0] hold;
  logic [1:0] rolls_left;
  logic       busy, roll_done, dice_valid;
  logic [14:0] dice_obs;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_lfsr, m_prev;
  logic [2:0]  exp_dice [5];
  logic [4:0]  exp_hold;

  dice_roll_controller #(
    .MAX_ROLLS  (3),
    .ANIM_TICKS (ANIM),
    .FRAME_DIV  (FDIV)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .turn_start  (turn_start),
    .roll_req    (roll_req),
    .hold_toggle (hold_toggle),
    .d1          (d1),
    .d2          (d2),
    .d3          (d3),
    .d4          (d4),
    .d5          (d5),
    .hold        (hold),
    .rolls_left  (rolls_left),
    .busy        (busy),
    .roll_done   (roll_done),
    .dice_valid  (dice_valid)
  );

  always #5 clk = ~clk;

  assign dice_obs = {d5, d4, d3, d2, d1};

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic [15:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  // Reference LFSR: m_prev is the state that was visible just before the last edge.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_lfsr <= 16'hACE1;
      m_prev <= 16'hACE1;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= lfsr_next(m_lfsr);
    end
  end

  function automatic logic [2:0] map6(input logic [15:0] v, input int i);
    int s;
    s = int'((v >> (3 * i)) & 16'h7);
    return 3'((s % 6) + 1);
  endfunction

  function automatic logic [14:0] pack_exp();
    return {exp_dice[4], exp_dice[3], exp_dice[2], exp_dice[1], exp_dice[0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_exp();
    exp_hold = 5'd0;
    for (int i = 0; i < 5; i++) exp_dice[i] = 3'd0;
  endtask

  task automatic do_roll(input logic [1:0] exp_rl);
    roll_req = 1'b1;
    step();
    roll_req = 1'b0;
    chk("accept_busy",  32'(busy), 32'd1);
    chk("accept_rolls", 32'(rolls_left), 32'(exp_rl));
    chk("accept_dice",  32'(dice_obs), 32'(pack_exp()));
    for (int k = 1; k <= ANIM; k++) begin
      step();
      if ((k % FDIV) == 0 || k == ANIM) begin
        for (int i = 0; i < 5; i++) begin
          if (!exp_hold[i]) exp_dice[i] = map6(m_prev, i);
        end
      end
      chk("anim_dice", 32'(dice_obs), 32'(pack_exp()));
      chk("anim_done", 32'(roll_done), (k == ANIM) ? 32'd1 : 32'd0);
      chk("anim_busy", 32'(busy), 32'd1);
    end
    chk("roll_valid", 32'(dice_valid), 32'd1);
    step();
    chk("post_done", 32'(roll_done), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_dice", 32'(dice_obs), 32'(pack_exp()));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_dice"},  32'(dice_obs), 32'd0);
    chk({tag, "_hold"},  32'(hold), 32'd0);
    chk({tag, "_rolls"}, 32'(rolls_left), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_done"},  32'(roll_done), 32'd0);
    chk({tag, "_valid"}, 32'(dice_valid), 32'd0);
  endtask

  initial begin
    clear_exp();

    #12;
    check_all_zero("reset");
    #11;
    reset_n = 1'b1;

    // Idle: roll requests and hold toggles must have no effect.
    for (int i = 0; i < 20; i++) begin
      roll_req    = (i % 4 == 1);
      hold_toggle = (i % 3 == 0) ? 5'h1F : 5'h00;
      step();
      chk("idle_busy",  32'(busy), 32'd0);
      chk("idle_rolls", 32'(rolls_left), 32'd0);
      chk("idle_dice",  32'(dice_obs), 32'd0);
      chk("idle_hold",  32'(hold), 32'd0);
    end
    roll_req    = 1'b0;
    hold_toggle = 5'd0;

    // New turn and first roll.
    turn_start = 1'b1;
    step();
    turn_start = 1'b0;
    chk("turn_rolls", 32'(rolls_left), 32'd3);
    chk("turn_dice",  32'(dice_obs), 32'd0);
    chk("turn_valid", 32'(dice_valid), 32'd0);
    chk("turn_busy",  32'(busy), 32'd0);
    do_roll(2'd2);

    // Hold dice 1 and 3, then roll twice to exhaust the turn.
    hold_toggle = 5'b00101;
    step();
    hold_toggle = 5'd0;
    exp_hold = 5'b00101;
    chk("hold_set", 32'(hold), 32'h05);
    do_roll(2'd1);
    do_roll(2'd0);

    // Locked: further requests and toggles are ignored.
    roll_req = 1'b1;
    step();
    roll_req = 1'b0;
    chk("locked_busy", 32'(busy), 32'd0);
    hold_toggle = 5'h1F;
    step();
    hold_toggle = 5'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("locked_busy2", 32'(busy), 32'd0);
      chk("locked_rolls", 32'(rolls_left), 32'd0);
      chk("locked_dice",  32'(dice_obs), 32'(pack_exp()));
      chk("locked_hold",  32'(hold), 32'h05);
    end

    // Abort an animation with turn_start sampled at t+4.
    turn_start = 1'b1;
    step();
    turn_start = 1'b0;
    clear_exp();
    roll_req = 1'b1;
    step();
    roll_req = 1'b0;
    chk("abort_accept", 32'(busy), 32'd1);
    for (int k = 1; k <= 3; k++) step();
    turn_start = 1'b1;
    step();
    turn_start = 1'b0;
    chk("abort_busy",  32'(busy), 32'd0);
    chk("abort_dice",  32'(dice_obs), 32'd0);
    chk("abort_hold",  32'(hold), 32'd0);
    chk("abort_rolls", 32'(rolls_left), 32'd3);
    chk("abort_valid", 32'(dice_valid), 32'd0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("abort_nodone", 32'(roll_done), 32'd0);
      chk("abort_idle",   32'(busy), 32'd0);
    end

    // Toggles before the first completed roll are ignored.
    hold_toggle = 5'h1F;
    step();
    hold_toggle = 5'd0;
    chk("pre_valid_hold", 32'(hold), 32'd0);
    do_roll(2'd2);

    // All held: roll is ignored.
    hold_toggle = 5'h1F;
    step();
    hold_toggle = 5'd0;
    exp_hold = 5'h1F;
    chk("all_held", 32'(hold), 32'h1F);
    roll_req = 1'b1;
    step();
    roll_req = 1'b0;
    chk("all_held_busy",  32'(busy), 32'd0);
    chk("all_held_rolls", 32'(rolls_left), 32'd2);

    hold_toggle = 5'h1F;
    step();
    hold_toggle = 5'd0;
    exp_hold = 5'h00;
    chk("unhold", 32'(hold), 32'd0);

    // Coincident toggle-all and roll: toggles first, so the roll is ignored.
    hold_toggle = 5'h1F;
    roll_req    = 1'b1;
    step();
    hold_toggle = 5'd0;
    roll_req    = 1'b0;
    exp_hold = 5'h1F;
    chk("coinc_busy",  32'(busy), 32'd0);
    chk("coinc_rolls", 32'(rolls_left), 32'd2);
    chk("coinc_hold",  32'(hold), 32'h1F);

    // Asynchronous reset in the middle of a roll.
    hold_toggle = 5'h1F;
    step();
    hold_toggle = 5'd0;
    roll_req = 1'b1;
    step();
    roll_req = 1'b0;
    chk("mid_accept", 32'(busy), 32'd1);
    step();
    step();
    #1;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    step();
    chk("async_rst_done", 32'(roll_done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
